lcd_rx: RTL
===========

Name: lcd_rx

Overview:
HD44780-compatible receiver and display model. It is the panel end of the en/rs/data[3:0] bus driven by our LCD driver.
- Samples nibbles on the falling edge of en.
- Reassembles bytes and decodes instructions.
- Maintains a 2-row character RAM that a read port or the bench inspects.
- Used in-fabric for loopback self-check and as the verification model for the driver.

Parameters:
COLS, 16, characters per row; power of two, 8 or 16. CHAR_AW = log2(2*COLS).
RESET_CHAR, 8'h20, value loaded into every cell on reset and on clear.

Ports:
clk  in  1  system clock; en/rs/data are synchronous to it
reset  in  1  asynchronous, active-low reset
en  in  1  LCD enable strobe; a transfer occurs on its 1->0 transition
rs  in  1  register select: 0 = instruction, 1 = data
data  in  4  D7..D4 nibble
rd_addr  in  CHAR_AW  cell index = row*COLS + col
rd_data  out  8  registered cell contents
cursor_addr  out  7  DDRAM address counter (row in bit 6, col in bits 3:0)
four_bit  out  1  interface-length flag (DL=0)
two_line  out  1  N bit from function set
display_on  out  1  D bit from display control
incr  out  1  I/D bit from entry mode
byte_valid  out  1  one-cycle pulse per completed byte
byte_out  out  8  the completed byte
byte_rs  out  1  rs latched with that byte
bad_addr  out  1  sticky; set DDRAM address with col >= COLS or bits 5:4 != 0

Behaviour:
- Edge detect: en_q registered each cycle; fall = en_q & ~en.
  - rs_q and data_q are registered copies taken while en_q=1.
  - On fall, (rs_q, data_q) is the transferred nibble.
- Reset (async, active-low) values:
  - FSM = MODE8; en_q=0; cursor_addr=0.
  - four_bit=0, two_line=0, display_on=0, incr=1.
  - byte_valid=0, byte_out=0, byte_rs=0, bad_addr=0, rd_data=0.
  - All cells = RESET_CHAR.
- FSM states:
  - MODE8: each nibble completes a byte {data_q,4'h0}; stay in MODE8 unless that byte clears DL.
  - HI: store nibble as the high half; go to LO.
  - LO: byte = {hi,data_q}; go to HI.
- Byte completion: byte_valid pulses the cycle after fall. byte_out and byte_rs are held until the next byte.
- Decode is priority-ordered on the MSB set when byte_rs=0; it takes effect in the same cycle as byte_valid.
  - 1xxxxxxx set DDRAM address: row = b6; col = b3:0 masked to COLS-1; set bad_addr if the condition holds.
  - 001xxxxx function set: four_bit = ~b4, two_line = b3. When DL changes, the FSM goes to HI (DL=0) or MODE8 (DL=1).
  - 0001xxxx cursor shift: see Optional Feature.
  - 00001xxx display control: display_on = b2.
  - 000001xx entry mode: incr = b1.
  - 00000010/3 return home: cursor_addr = 0.
  - 00000001 clear: all cells = RESET_CHAR, cursor_addr = 0, incr = 1; single cycle.
- Data byte (byte_rs=1): cell[row*COLS+col] = byte, then the cursor moves by one.
- Cursor movement:
  - incr=1 goes to col+1. Col COLS-1 wraps to col 0 of the other row (row0->row1, row1->row0).
  - incr=0 goes to col-1. Col 0 wraps to col COLS-1 of the other row.
- No busy flag: every instruction completes in one cycle. The bus may deliver the next nibble on any later cycle.
- Read port: rd_data = cell[rd_addr], latency 1 cycle. Same-cycle write to the read cell returns the old value.
- An en falling edge in the same cycle that the previous byte decodes: both are honoured, because decode is pipelined one stage.
- Reset asserted mid-byte discards the partial nibble; after release the FSM is MODE8.

Optional Feature:
LCD_RX_SHIFT_EN.
- Defined: cursor shift with b3 (S/C) = 0 moves cursor_addr by one, using the wrap rules, in the b2 (R/L) direction (1 = right).
- Defined: S/C = 1 leaves cursor_addr unchanged.
- Undefined: all 0001xxxx bytes are ignored apart from byte_valid.

Decomposition:
- Package lcd_pkg holds:
  - Instruction opcode masks (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPCTL, CMD_SHIFT, CMD_FUNC, CMD_DDRAM).
  - Bit positions (DL, N, D, ID, SC, RL).
  - Row base addresses (ROW0=7'h00, ROW1=7'h40).
  - The FSM state enum.
- One natural sub-module, lcd_rx_nibble: edge detect, nibble assembly and the mode FSM. It outputs byte_valid/byte_out/byte_rs.
- The top level holds decode, cursor and cell RAM.

Test Plan:
- Driver init nibbles 3,3,3,2 (rs=0), then bytes 28,0C,06,01 in pairs -> four_bit=1, two_line=1, display_on=1, incr=1, cursor_addr=0, all cells 0x20.
- After init, rs=1 nibbles 4,8 then 6,9 -> cell0=0x48, cell1=0x69, cursor_addr=0x02. A rd_addr=1 read returns 0x69 one cycle later.
- Instruction 0xCB, then data 0x31,0x32 -> cells 27,28 = 0x31,0x32 and cursor_addr=0x4D. Instruction 0x9F -> bad_addr=1.
- With incr=1 at cursor 0x0F, write 0x41 -> cell15=0x41, cursor_addr=0x40. With incr=0 at 0x40, a write wraps the cursor to 0x0F.
- Send high nibble 4 only, pulse reset low for 1 cycle -> after release the FSM is MODE8, four_bit=0, cells=0x20; a single nibble 2 then sets four_bit=1.
- LCD_RX_SHIFT_EN defined: 0x14 at cursor 0x05 gives 0x06, and 0x18 leaves it unchanged. LCD_RX_SHIFT_EN undefined: 0x14 gives no change, with byte_valid pulsing.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared HD44780 instruction masks, bit positions, row bases and receiver mode states.
// Pure definitions, no logic; used by lcd_rx and lcd_rx_nibble.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam int BIT_DL = 4;
    localparam int BIT_N  = 3;
    localparam int BIT_D  = 2;
    localparam int BIT_ID = 1;
    localparam int BIT_SC = 3;
    localparam int BIT_RL = 2;

    localparam logic [6:0] ROW0 = 7'h00;
    localparam logic [6:0] ROW1 = 7'h40;

    typedef enum logic [1:0] {
        MODE8 = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } mode_e;

    function automatic logic is_func_set(input logic [7:0] b);
        return (b & 8'hE0) == CMD_FUNC;
    endfunction

    function automatic logic shift_moves_cursor(input logic [7:0] b);
        return !b[BIT_SC];
    endfunction

    function automatic logic shift_right(input logic [7:0] b);
        return b[BIT_RL];
    endfunction

endpackage

// File: rtl/lcd_rx_nibble.sv
// Samples (rs, data) on the falling edge of en and assembles bytes in 8- or 4-bit mode.
// Latency: byte_valid pulses the cycle after the en fall; no backpressure, every fall is taken.
module lcd_rx_nibble
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rs,
    input  logic [3:0] data,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs
);

    logic       en_q, en_d;
    logic       rs_q, rs_d;
    logic [3:0] data_q, data_d;
    logic [3:0] hi_q, hi_d;
    mode_e      state_q, state_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_rs_q, byte_rs_d;

    logic       fall;
    logic       done;
    logic [7:0] nb;

    assign fall = en_q & ~en;

    always_comb begin
        en_d         = en;
        rs_d         = rs_q;
        data_d       = data_q;
        hi_d         = hi_q;
        state_d      = state_q;
        byte_valid_d = 1'b0;
        byte_out_d   = byte_out_q;
        byte_rs_d    = byte_rs_q;
        done         = 1'b0;
        nb           = byte_out_q;

        if (en) begin
            rs_d   = rs;
            data_d = data;
        end

        if (fall) begin
            case (state_q)
                MODE8: begin
                    done = 1'b1;
                    nb   = {data_q, 4'h0};
                end
                HI: begin
                    hi_d    = data_q;
                    state_d = LO;
                end
                default: begin
                    done    = 1'b1;
                    nb      = {hi_q, data_q};
                    state_d = HI;
                end
            endcase

            if (done) begin
                byte_valid_d = 1'b1;
                byte_out_d   = nb;
                byte_rs_d    = rs_q;
                // Mode switch is resolved here so a nibble arriving while the
                // function-set byte decodes is already framed in the new mode.
                if (!rs_q && is_func_set(nb)) begin
                    state_d = nb[BIT_DL] ? MODE8 : HI;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q         <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 4'h0;
            hi_q         <= 4'h0;
            state_q      <= MODE8;
            byte_valid_q <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_rs_q    <= 1'b0;
        end else begin
            en_q         <= en_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            hi_q         <= hi_d;
            state_q      <= state_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            byte_rs_q    <= byte_rs_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_rs    = byte_rs_q;

endmodule

// File: rtl/lcd_rx.sv
// HD44780-style panel model: decodes received bytes, tracks the cursor, holds a 2-row char RAM.
// Latency: decode commits in the byte_valid cycle, rd_data one cycle after rd_addr; no backpressure.
// Optional cursor-shift instruction support is enabled by defining LCD_RX_SHIFT_EN.
module lcd_rx
    import lcd_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter logic [7:0] RESET_CHAR = 8'h20,
    localparam int        CHAR_AW    = $clog2(2 * COLS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               rs,
    input  logic [3:0]         data,
    input  logic [CHAR_AW-1:0] rd_addr,
    output logic [7:0]         rd_data,
    output logic [6:0]         cursor_addr,
    output logic               four_bit,
    output logic               two_line,
    output logic               display_on,
    output logic               incr,
    output logic               byte_valid,
    output logic [7:0]         byte_out,
    output logic               byte_rs,
    output logic               bad_addr
);

    localparam int CW = CHAR_AW - 1;

    logic       bv;
    logic [7:0] b;
    logic       brs;

    lcd_rx_nibble u_nibble (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rs         (rs),
        .data       (data),
        .byte_valid (bv),
        .byte_out   (b),
        .byte_rs    (brs)
    );

    // Cursor is kept as the linear cell index {row, col}; with COLS a power of
    // two, +/-1 modulo 2*COLS gives exactly the row-to-row wrap behaviour.
    logic [CHAR_AW-1:0] pos_q, pos_d;
    logic               four_bit_q, four_bit_d;
    logic               two_line_q, two_line_d;
    logic               display_on_q, display_on_d;
    logic               incr_q, incr_d;
    logic               bad_addr_q, bad_addr_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [7:0]         cells_q [2*COLS];
    logic [7:0]         cells_d [2*COLS];

    function automatic logic [CHAR_AW-1:0] step(input logic [CHAR_AW-1:0] p, input logic up);
        return up ? p + CHAR_AW'(1) : p - CHAR_AW'(1);
    endfunction

    always_comb begin
        pos_d        = pos_q;
        four_bit_d   = four_bit_q;
        two_line_d   = two_line_q;
        display_on_d = display_on_q;
        incr_d       = incr_q;
        bad_addr_d   = bad_addr_q;
        rd_data_d    = cells_q[rd_addr];
        cells_d      = cells_q;

        if (bv) begin
            if (brs) begin
                cells_d[pos_q] = b;
                pos_d          = step(pos_q, incr_q);
            end else if (|(b & CMD_DDRAM)) begin
                pos_d = {b[6], b[CW-1:0]};
                if (({28'd0, b[3:0]} >= 32'(COLS)) || (b[5:4] != 2'b00)) begin
                    bad_addr_d = 1'b1;
                end
            end else if (b[6]) begin
                // CGRAM address set: no CGRAM is modelled
            end else if (|(b & CMD_FUNC)) begin
                four_bit_d = ~b[BIT_DL];
                two_line_d = b[BIT_N];
            end else if (|(b & CMD_SHIFT)) begin
`ifdef LCD_RX_SHIFT_EN
                if (shift_moves_cursor(b)) begin
                    pos_d = step(pos_q, shift_right(b));
                end
`endif
            end else if (|(b & CMD_DISPCTL)) begin
                display_on_d = b[BIT_D];
            end else if (|(b & CMD_ENTRY)) begin
                incr_d = b[BIT_ID];
            end else if (|(b & CMD_HOME)) begin
                pos_d = '0;
            end else if (b == CMD_CLEAR) begin
                for (int i = 0; i < 2 * COLS; i++) begin
                    cells_d[i] = RESET_CHAR;
                end
                pos_d  = '0;
                incr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q        <= '0;
            four_bit_q   <= 1'b0;
            two_line_q   <= 1'b0;
            display_on_q <= 1'b0;
            incr_q       <= 1'b1;
            bad_addr_q   <= 1'b0;
            rd_data_q    <= 8'h00;
            for (int i = 0; i < 2 * COLS; i++) begin
                cells_q[i] <= RESET_CHAR;
            end
        end else begin
            pos_q        <= pos_d;
            four_bit_q   <= four_bit_d;
            two_line_q   <= two_line_d;
            display_on_q <= display_on_d;
            incr_q       <= incr_d;
            bad_addr_q   <= bad_addr_d;
            rd_data_q    <= rd_data_d;
            for (int i = 0; i < 2 * COLS; i++) begin
                cells_q[i] <= cells_d[i];
            end
        end
    end

    assign cursor_addr = (pos_q[CW] ? ROW1 : ROW0) | 7'(pos_q[CW-1:0]);
    assign four_bit    = four_bit_q;
    assign two_line    = two_line_q;
    assign display_on  = display_on_q;
    assign incr        = incr_q;
    assign bad_addr    = bad_addr_q;
    assign rd_data     = rd_data_q;
    assign byte_valid  = bv;
    assign byte_out    = b;
    assign byte_rs     = brs;

endmodule
